// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared constants for the coprocessor-0 responder.
//   CP0 register numbers as seen on the MFC0/MTC0 address ports, and the bit
//   positions of the SR/Cause fields that the unit implements.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    localparam int unsigned IM_HI   = 15;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned IE_BIT  = 0;

    localparam int unsigned HWINT_W = IM_HI - IM_LO + 1;

endpackage

// File: rtl/cp0_unit_sync.sv
// cp0_unit_sync: multi-flop synchroniser for the external interrupt lines.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every stage
//   d_i    : asynchronous input lines
//   q_o    : synchronised lines, SYNC_STAGES clocks behind d_i
module cp0_unit_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 responder for the 5-stage MIPS pipeline.
//   Holds SR (IM/EXL/IE), Cause (IP), EPC and PRId; synchronises HWInt and
//   raises a one-cycle registered interrupt request to the fetch-stage control.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   A1 / DOut  : MFC0 read address / combinational read data
//   A2/DIn/We  : MTC0 write address / data / enable
//   PC         : victim word address captured on EPCWr
//   HWInt      : asynchronous active-high interrupt lines
//   EPCWr, EXLSet, EXLClr : control strobes (EPC capture, entry, ERET)
//   IntReq     : interrupt request pulse
//   EPC        : saved return word address
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VAL    = 32'h4A57_0001,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [29:0] PC,
    input  logic [5:0]  HWInt,
    input  logic        EPCWr,
    input  logic        EXLSet,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [29:0] EPC,
    output logic [31:0] DOut
);

    logic [HWINT_W-1:0] hw_s;

    logic [HWINT_W-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic [HWINT_W-1:0] ip_q;
    logic [29:0]        epc_q, epc_d;
    logic               intreq_q, intreq_d;
    logic               armed_q, armed_d;
    logic               int_cond;
    logic               wr_sr, wr_epc;

    cp0_unit_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (HWINT_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (HWInt),
        .q_o   (hw_s)
    );

    assign wr_sr  = We && (A2 == CP0_REG_SR);
    assign wr_epc = We && (A2 == CP0_REG_EPC);

    assign int_cond = (|(ip_q & im_q)) & ie_q & ~exl_q;

    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;

        if (wr_sr) begin
            im_d  = DIn[IM_HI:IM_LO];
            ie_d  = DIn[IE_BIT];
            exl_d = DIn[EXL_BIT];
        end
        if (EXLSet) begin
            exl_d = 1'b1;
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end

        if (EPCWr) begin
            epc_d = PC;
        end else if (wr_epc) begin
            epc_d = DIn[31:2];
        end

        // armed drops after a pulse that control ignored, and only returns once
        // the condition has gone away or an ERET happens, so an unanswered
        // request is never repeated on a steady level.
        armed_d = armed_q;
        if (!int_cond || EXLClr) begin
            armed_d = 1'b1;
        end else if (intreq_q) begin
            armed_d = 1'b0;
        end

        intreq_d = int_cond & armed_q & ~intreq_q & ~EXLSet;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_q     <= '0;
            exl_q    <= 1'b0;
            ie_q     <= 1'b0;
            ip_q     <= '0;
            epc_q    <= '0;
            intreq_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            im_q     <= im_d;
            exl_q    <= exl_d;
            ie_q     <= ie_d;
            ip_q     <= hw_s;
            epc_q    <= epc_d;
            intreq_q <= intreq_d;
            armed_q  <= armed_d;
        end
    end

    // Reads see registered state only: an MFC0 alongside an MTC0 to the same
    // register returns the pre-write value.
    always_comb begin
        DOut = '0;
        case (A1)
            CP0_REG_SR:    DOut = {16'b0, im_q, 8'b0, exl_q, ie_q};
            CP0_REG_CAUSE: DOut = {16'b0, ip_q, 10'b0};
            CP0_REG_EPC:   DOut = {epc_q, 2'b00};
            CP0_REG_PRID:  DOut = PRID_VAL;
            default:       DOut = '0;
        endcase
    end

    assign IntReq = intreq_q;
    assign EPC    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        We;
    logic [29:0] PC;
    logic [5:0]  HWInt;
    logic        EPCWr, EXLSet, EXLClr;
    logic        IntReq;
    logic [29:0] EPC;
    logic [31:0] DOut;

    cp0_unit #(
        .PRID_VAL    (32'h4A57_0001),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A1     (A1),
        .A2     (A2),
        .DIn    (DIn),
        .We     (We),
        .PC     (PC),
        .HWInt  (HWInt),
        .EPCWr  (EPCWr),
        .EXLSet (EXLSet),
        .EXLClr (EXLClr),
        .IntReq (IntReq),
        .EPC    (EPC),
        .DOut   (DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_t e;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow observed=%h required=queued_entry", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        push(tag, exp);
        #1;
        pop_check(DOut);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        push(tag, {31'b0, exp});
        pop_check({31'b0, IntReq});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        We = 1'b1; A2 = a; DIn = d;
        tick();
        We = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; A1 = '0; A2 = '0; DIn = '0; We = 1'b0; PC = '0;
        HWInt = '0; EPCWr = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();

        // reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h4A57_0001);
        rd("rst_unmapped", 5'd7, 32'h0);
        chk_irq("rst_intreq", 1'b0);

        // MTC0 SR; same-cycle read sees the old value
        We = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03;
        rd("sr_no_bypass", 5'd12, 32'h0);
        tick();
        We = 1'b0;
        rd("sr_write", 5'd12, 32'h0000_FC03);

        // MTC0 EPC
        mtc0(5'd14, 32'h0000_3010);
        push("epc_port", 32'h0000_0C04);
        pop_check({2'b0, EPC});
        rd("epc_read", 5'd14, 32'h0000_3010);

        // writes to read-only / unmapped registers are ignored
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0);
        rd("prid_ro", 5'd15, 32'h4A57_0001);
        rd("sr_untouched", 5'd12, 32'h0000_FC03);

        // enabled interrupt: IntReq only in cycle 4 after HWInt rises
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_irq($sformatf("irq_lat_c%0d", i), (i == 4));
        end
        EPCWr = 1'b1; EXLSet = 1'b1; PC = 30'h0C05;
        tick();
        EPCWr = 1'b0; EXLSet = 1'b0;
        chk_irq("irq_after_entry", 1'b0);
        rd("entry_epc", 5'd14, 32'h0000_3014);
        rd("entry_sr", 5'd12, 32'h0000_0403);
        rd("entry_cause", 5'd13, 32'h0000_0400);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_irq("irq_in_handler", 1'b0);
        end

        // ERET re-arm: pulse once the cycle after EXL clears, then never again
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk_irq("eret_edge", 1'b0);
        tick();
        chk_irq("eret_pulse", 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_irq("ignored_no_repeat", 1'b0);
        end

        // masked interrupt: IP tracks HWInt, no request
        mtc0(5'd12, 32'h0000_0801);
        rd("mask_cause", 5'd13, 32'h0000_0400);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_irq("masked", 1'b0);
        end

        // IE=0: no request even with matching IM
        mtc0(5'd12, 32'h0000_0400);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_irq("ie_off", 1'b0);
        end

        // EPCWr beats MTC0 to EPC
        EPCWr = 1'b1; PC = 30'h1; We = 1'b1; A2 = 5'd14; DIn = 32'hFFFF_FFFC;
        tick();
        EPCWr = 1'b0; We = 1'b0;
        rd("epc_prio", 5'd14, 32'h0000_0004);

        // EXLSet with EXLClr and an MTC0 clearing EXL: EXL ends up set
        EXLSet = 1'b1; EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0801;
        tick();
        EXLSet = 1'b0; EXLClr = 1'b0; We = 1'b0;
        rd("exl_prio", 5'd12, 32'h0000_0803);

        // EXLClr beats MTC0 setting EXL
        EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0C03;
        tick();
        EXLClr = 1'b0; We = 1'b0;
        rd("exlclr_prio", 5'd12, 32'h0000_0C01);

        // async reset mid-cycle while EXL=1
        EXLSet = 1'b1;
        tick();
        EXLSet = 1'b0;
        rd("pre_reset_sr", 5'd12, 32'h0000_0C03);
        #2 rst_n = 1'b0;
        #1;
        rd("async_rst_sr", 5'd12, 32'h0);
        rd("async_rst_cause", 5'd13, 32'h0);
        chk_irq("async_rst_intreq", 1'b0);
        push("async_rst_epc", 32'h0);
        pop_check({2'b0, EPC});
        tick();
        #2 rst_n = 1'b1;
        HWInt = '0;
        tick();

        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover observed=%0d required=0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 responder for the 5-stage MIPS pipeline; the other end of the fetch-stage control's interrupt and ERET/MTC0 signalling.
- Consumes the write-enable, EPC-write, EXL-set and EXL-clear strobes issued by the fetch-stage control. Returns the interrupt request, the saved EPC, and MFC0 read data.
- Synchronises the 6 external hardware interrupt lines and holds SR, Cause, EPC and PRId.

Parameters:
- PRID_VAL, 32'h4A57_0001, constant returned on reads of register 15.
- SYNC_STAGES, 2, flip-flop stages on each HWInt line (legal values 2–3).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- A1  input  5  MFC0 read register number.
- A2  input  5  MTC0 write register number.
- DIn  input  32  MTC0 write data.
- We  input  1  MTC0 write enable (CP0_Wen from control).
- PC  input  30  word address of the victim instruction (PC[31:2]).
- HWInt  input  6  asynchronous external interrupt lines, active-high level.
- EPCWr  input  1  capture PC into EPC.
- EXLSet  input  1  set SR.EXL (interrupt entry).
- EXLClr  input  1  clear SR.EXL (ERET).
- IntReq  output  1  one-cycle interrupt request pulse to control.
- EPC  output  30  saved return word address for the ERET next-PC path.
- DOut  output  32  MFC0 read data.

Behaviour:
- Reset (async, rst_n=0):
  - SR.IM[15:10]=0, SR.EXL[1]=0, SR.IE[0]=0.
  - Cause.IP[15:10]=0, EPC=0.
  - All synchroniser flops=0, IntReq=0.
  - Reset mid-handler drops EXL and the pending pulse immediately; no state survives.
- Register map:
  - 12 SR: bits 15:10 IM, 1 EXL, 0 IE; all other bits read 0.
  - 13 Cause: bits 15:10 IP; all other bits read 0; read-only.
  - 14 EPC: {EPC,2'b00}.
  - 15 PRId: PRID_VAL.
  - Any other address reads 32'h0; writes to it are ignored.
- Synchroniser: HWInt passes SYNC_STAGES flops to give hw_s. Each clk, Cause.IP <= hw_s.
- MTC0, on the clk edge when We=1:
  - A2=12 writes IM, EXL, IE from DIn.
  - A2=14 writes EPC <= DIn[31:2].
  - A2=13 and A2=15 are ignored.
- EXL priority within one edge: EXLSet > EXLClr > MTC0 write to SR.EXL.
- EPC priority within one edge: EPCWr (EPC<=PC) > MTC0 to reg 14.
- IntReq, registered:
  - int_cond = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
  - IntReq_next = int_cond & ~IntReq & ~EXLSet.
  - Result: at most one-cycle pulse per entry. No re-request while EXL=1 or in the cycle EXL is being set.
- Latency:
  - HWInt to Cause.IP: SYNC_STAGES+1 cycles.
  - Cause.IP to IntReq: 1 cycle.
  - With SYNC_STAGES=2, IntReq is high in the 4th cycle after HWInt rises, if enabled.
- Pulse cancel: if IntReq was asserted but control does not return EPCWr/EXLSet, the pulse is not repeated until int_cond falls and rises again or EXL toggles. Implemented with a one-bit "armed" flag cleared by IntReq and re-set when int_cond=0 or EXLClr=1.
- DOut: combinational from current register state, no write-through bypass. MFC0 in the same cycle as MTC0 to the same register returns the old value.
- IE=0 or IM bit 0: IP still tracks HWInt; IntReq stays 0.
- Simultaneous EXLSet and EXLClr: EXL=1.

Decomposition:
- Shared package/header: CP0 register numbers (SR=12, Cause=13, EPC=14, PRId=15), SR/Cause bit positions (IM_HI=15, IM_LO=10, EXL=1, IE=0).
- One sub-module: cp0_sync, a parameterised SYNC_STAGES-deep, 6-bit-wide synchroniser with async active-low reset.

Test Plan:
- Reset then read: release rst_n; read A1=12,13,14 -> DOut=0; A1=15 -> 32'h4A57_0001; A1=7 -> 0.
- MTC0 SR and EPC: We=1, A2=12, DIn=32'h0000_FC03 -> SR reads 32'h0000_FC03 next cycle. A2=14, DIn=32'h0000_3010 -> EPC=30'h0C04.
- Enabled interrupt: SR=32'h0000_0401, HWInt[0] raised at cycle 0 -> IntReq=1 only in cycle 4. Drive EPCWr=EXLSet=1 with PC=30'h0C05 that cycle -> EXL=1, EPC reads 32'h0000_3014, no further IntReq.
- Masked interrupt: SR=32'h0000_0801 (IM bit 11 only), HWInt[0]=1 -> Cause reads 32'h0000_0400, IntReq stays 0 for 20 cycles.
- ERET re-arm: from the handled state with HWInt[0] still high, EXLClr=1 -> EXL=0 next edge, IntReq pulses once the following cycle.
- Priority and async reset: EPCWr=1 with PC=30'h1 plus We=1, A2=14, DIn=32'hFFFF_FFFC in one edge -> EPC reads 32'h0000_0004. Assert rst_n=0 mid-cycle while EXL=1 -> EXL=0 and IntReq=0 before the next clk edge.
